// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge: single-beat AXI master serving one memory-stage load or store at a time.
module mem_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_data_ren,
  input  logic        mem_data_wen,
  input  logic [3:0]  mem_data_wsel,
  input  logic [31:0] mem_data_addr,
  input  logic [31:0] mem_data_wdata,
  input  logic        cached_trans,
  output logic [31:0] mem_data_rdata,
  output logic        mem_data_rvalid,
  output logic        mem_data_bvalid,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [3:0]  arcache,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [3:0]  awcache,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] wsel_q, wsel_d;
  logic cached_q, cached_d, wr_q, wr_d, aw_done_q, aw_done_d, w_done_q, w_done_d, cancel_q, cancel_d;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs, req_drop;
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, rlast, bid, bresp};
  assign arid    = AXI_ID;
  assign awid    = AXI_ID;
  assign wid     = AXI_ID;
  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arsize  = 3'b010;
  assign awsize  = 3'b010;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign wlast   = 1'b1;
  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign arcache = cached_q ? 4'b1111 : 4'b0000;
  assign awcache = cached_q ? 4'b1111 : 4'b0000;
  assign wdata   = wdata_q;
  assign wstrb   = wsel_q;
  assign arvalid = state_q == RD_ADDR;
  assign rready  = state_q == RD_DATA;
  assign awvalid = state_q == WR_REQ && !aw_done_q;
  assign wvalid  = state_q == WR_REQ && !w_done_q;
  assign bready  = state_q == WR_RESP;
  assign ar_hs   = arvalid && arready;
  assign r_hs    = rready && rvalid;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign b_hs    = bready && bvalid;
  assign mem_data_rdata  = rdata_q;
  assign mem_data_rvalid = state_q == DONE && !wr_q && !cancel_q;
  assign mem_data_bvalid = state_q == DONE && wr_q && !cancel_q;
  // A dropped request still finishes on AXI; only the completion pulse is withheld.
  assign req_drop = wr_q ? !mem_data_wen : !mem_data_ren;
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wsel_d    = wsel_q;
    cached_d  = cached_q;
    wr_d      = wr_q;
    aw_done_d = aw_done_q || aw_hs;
    w_done_d  = w_done_q || w_hs;
    cancel_d  = cancel_q || (state_q != IDLE && state_q != DONE && req_drop);
    rdata_d   = r_hs ? rdata : rdata_q;
    case (state_q)
      IDLE: begin
        cancel_d  = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (mem_data_ren) begin
          addr_d   = mem_data_addr;
          cached_d = cached_trans;
          wr_d     = 1'b0;
          state_d  = RD_ADDR;
        end else if (mem_data_wen) begin
          addr_d   = mem_data_addr;
          wdata_d  = mem_data_wdata;
          wsel_d   = mem_data_wsel;
          cached_d = cached_trans;
          wr_d     = 1'b1;
          state_d  = WR_REQ;
        end
      end
      RD_ADDR: state_d = ar_hs ? RD_DATA : RD_ADDR;
      RD_DATA: state_d = r_hs ? DONE : RD_DATA;
      WR_REQ:  state_d = (aw_done_d && w_done_d) ? WR_RESP : WR_REQ;
      WR_RESP: state_d = b_hs ? DONE : WR_RESP;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wsel_q    <= '0;
      rdata_q   <= '0;
      cached_q  <= 1'b0;
      wr_q      <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cancel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wsel_q    <= wsel_d;
      rdata_q   <= rdata_d;
      cached_q  <= cached_d;
      wr_q      <= wr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cancel_q  <= cancel_d;
    end
  end
endmodule

// File: doc/mem_axi_bridge.md
MEM_AXI_BRIDGE -- requirements
Module: mem_axi_bridge

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on its rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-003 SHALL have ports: mem_data_ren  in  1, mem_data_wen  in  1, mem_data_wsel  in  4, mem_data_addr  in  32 (word-aligned), mem_data_wdata  in  32, cached_trans  in  1 -- request from memory stage.
REQ-004 SHALL have ports: mem_data_rdata  out  32, mem_data_rvalid  out  1, mem_data_bvalid  out  1 -- completion to memory stage.
REQ-005 SHALL have AXI read ports: arid out 4, araddr out 32, arlen out 8, arsize out 3, arburst out 2, arcache out 4, arvalid out 1, arready in 1; rid in 4, rdata in 32, rresp in 2, rlast in 1, rvalid in 1, rready out 1.
REQ-006 SHALL have AXI write ports: awid out 4, awaddr out 32, awlen out 8, awsize out 3, awburst out 2, awcache out 4, awvalid out 1, awready in 1; wid out 4, wdata out 32, wstrb out 4, wlast out 1, wvalid out 1, wready in 1; bid in 4, bresp in 2, bvalid in 1, bready out 1.
REQ-007 SHALL have parameter AXI_ID, default 4'd1, id driven on arid/awid/wid.

Function
REQ-008 SHALL drive constants: arlen/awlen 0, arsize/awsize 3'b010, arburst/awburst 2'b01, wlast 1.
REQ-009 SHALL drive arcache/awcache 4'b1111 when latched cached_trans=1, else 4'b0000.
REQ-010 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
REQ-011 SHALL, in IDLE with ren=1, latch addr/cached_trans and go to RD_ADDR next cycle; ren has priority when ren=wen=1.
REQ-012 SHALL, in IDLE with wen=1 and ren=0, latch addr/wdata/wsel/cached_trans and go to WR_REQ.
REQ-013 SHALL hold arvalid=1 in RD_ADDR with latched araddr until arvalid&arready, then go to RD_DATA.
REQ-014 SHALL hold rready=1 in RD_DATA; on rvalid&rready latch rdata and go to DONE.
REQ-015 SHALL, in WR_REQ, assert awvalid and wvalid together; each drops independently after its own handshake (tracked by aw_done/w_done flags); when both done go to WR_RESP.
REQ-016 SHALL drive wstrb = latched wsel, wdata = latched wdata.
REQ-017 SHALL hold bready=1 in WR_RESP; on bvalid&bready go to DONE.
REQ-018 SHALL, in DONE, pulse mem_data_rvalid (read) or mem_data_bvalid (write) for exactly one cycle, then return to IDLE; next request accepted no earlier than the cycle after DONE.
REQ-019 SHALL hold mem_data_rdata stable from DONE until next read completes.
REQ-020 SHALL ignore rresp/bresp/rid/bid values; no error reporting.
REQ-021 SHALL, if the issuing request (ren or wen) drops before DONE, complete the AXI transaction and suppress the DONE pulse (cancel flag latched, cleared in IDLE).
REQ-022 SHALL ignore request inputs outside IDLE.
REQ-023 SHALL keep minimum read latency: request in IDLE at cycle 0, arready=1 and rvalid=1 immediately -> rvalid pulse at cycle 3.

Reset
REQ-024 SHALL on rst_n=0 asynchronously set FSM IDLE, clear arvalid, rready, awvalid, wvalid, bready, mem_data_rvalid, mem_data_bvalid, aw_done, w_done, cancel, mem_data_rdata=0, latched addr/wdata/wsel=0.
REQ-025 SHALL, on reset mid-transaction, abandon the transaction without completion pulse; resume in IDLE on first edge after release.

Verification
REQ-026 Read: ren=1 addr 0x8000_0010 cached=1, arready=1, rvalid next cycle rdata 0xDEADBEEF -> araddr 0x8000_0010, arcache 4'hF, one-cycle mem_data_rvalid with rdata 0xDEADBEEF.
REQ-027 Write: wen=1 addr 0xA000_0004 wsel 4'b0011 wdata 0x12341234, awready 2 cycles late, wready immediate, bvalid 1 cycle later -> awvalid held 3 cycles, wvalid 1 cycle, wstrb 4'b0011, awcache 0, single mem_data_bvalid pulse.
REQ-028 Back-pressure: arready low 5 cycles -> araddr/arvalid stable throughout, no rvalid pulse before handshake.
REQ-029 Cancel: ren dropped while in RD_DATA -> rready still completes R handshake, no mem_data_rvalid pulse, FSM back to IDLE.
REQ-030 Simultaneous ren=wen=1 -> read transaction only, no awvalid.
REQ-031 rst_n low during WR_REQ -> awvalid/wvalid 0 immediately (asynchronous), no bvalid pulse after release.
